// File: rtl/fpga_bram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fpga_bram_ctrl
//  Brief    : Sequences the shared address/data bus between the CPU-to-FPGA
//             command FIFO, a local 64-bit BRAM and the FPGA-to-CPU response
//             FIFO. Decodes WRITE/READ packets, owns bus turnaround, and
//             flags malformed requests with a sticky error bit.
//  Revision : 1.0 - initial release
// ============================================================================
module fpga_bram_ctrl #(
  parameter int ADDRESS_DATA_WIDTH = 33,
  parameter int BRAM_DEPTH         = 1024,
  localparam int AW                = $clog2(BRAM_DEPTH)
) (
  input  logic                          fpga_clk,
  input  logic                          rst,
  input  logic                          empty_CPU_to_FPGA_FIFO,
  input  logic                          full_FPGA_to_CPU_FIFO,
  output logic                          r_en_CPU_to_FPGA_FIFO,
  output logic                          w_en_FPGA_to_CPU_FIFO,
  inout  wire [ADDRESS_DATA_WIDTH-1:0]  address_data_bus,
  output logic                          bram_en,
  output logic                          bram_we,
  output logic [AW-1:0]                 bram_addr,
  output logic [63:0]                   bram_wdata,
  input  logic [63:0]                   bram_rdata,
  output logic                          busy,
  output logic                          error
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_HDR_CAP = 4'd1,
    S_D0_REQ  = 4'd2,
    S_D0_CAP  = 4'd3,
    S_D1_REQ  = 4'd4,
    S_D1_CAP  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_MEM_RD  = 4'd7,
    S_RD_CAP  = 4'd8,
    S_TURN    = 4'd9,
    S_OUT_LO  = 4'd10,
    S_OUT_HI  = 4'd11
  } state_e;

  localparam logic [31:0] DEPTH32 = 32'(BRAM_DEPTH);

  state_e                        state_q, state_d;
  logic                          legal_q;
  logic [AW-1:0]                 addr_q;
  logic [63:0]                   wdata_q;
  logic [63:0]                   rdata_q;
  logic                          error_q;

  logic                          pop;
  logic                          push;
  logic                          mem_en;
  logic                          mem_we;
  logic                          hdr_legal;
  logic [ADDRESS_DATA_WIDTH-1:0] out_word;

  // A header is legal when 8-byte aligned and its word index fits the BRAM.
  assign hdr_legal = (address_data_bus[2:0] == 3'b000) &&
                     ({3'b000, address_data_bus[31:3]} < DEPTH32);

  // State register.
  always_ff @(posedge fpga_clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobe decode; pops/pushes only fire when the FIFO allows.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    push    = 1'b0;
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_CPU_to_FPGA_FIFO) begin
          pop     = 1'b1;
          state_d = S_HDR_CAP;
        end
      end
      S_HDR_CAP: begin
        state_d = address_data_bus[32] ? S_D0_REQ : S_MEM_RD;
      end
      S_D0_REQ: begin
        if (!empty_CPU_to_FPGA_FIFO) begin
          pop     = 1'b1;
          state_d = S_D0_CAP;
        end
      end
      S_D0_CAP: begin
        state_d = S_D1_REQ;
      end
      S_D1_REQ: begin
        if (!empty_CPU_to_FPGA_FIFO) begin
          pop     = 1'b1;
          state_d = S_D1_CAP;
        end
      end
      S_D1_CAP: begin
        state_d = S_MEM_WR;
      end
      S_MEM_WR: begin
        mem_en  = legal_q;
        mem_we  = legal_q;
        state_d = S_IDLE;
      end
      S_MEM_RD: begin
        mem_en  = legal_q;
        state_d = S_RD_CAP;
      end
      S_RD_CAP: begin
        state_d = S_TURN;
      end
      S_TURN: begin
        state_d = S_OUT_LO;
      end
      S_OUT_LO: begin
        if (!full_FPGA_to_CPU_FIFO) begin
          push    = 1'b1;
          state_d = S_OUT_HI;
        end
      end
      S_OUT_HI: begin
        if (!full_FPGA_to_CPU_FIFO) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Header/data/read-data capture and the sticky error flag.
  always_ff @(posedge fpga_clk or negedge rst) begin
    if (!rst) begin
      legal_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        S_HDR_CAP: begin
          legal_q <= hdr_legal;
          addr_q  <= hdr_legal ? address_data_bus[AW+2:3] : '0;
          if (!hdr_legal) begin
            error_q <= 1'b1;
          end
        end
        S_D0_CAP: wdata_q[31:0]  <= address_data_bus[31:0];
        S_D1_CAP: wdata_q[63:32] <= address_data_bus[31:0];
        S_RD_CAP: rdata_q        <= legal_q ? bram_rdata : 64'd0;
        default:  ;
      endcase
    end
  end

  // Response word: low half first, high half tagged with the last-word flag.
  always_comb begin
    out_word = '0;
    if (state_q == S_OUT_HI) begin
      out_word[32]   = 1'b1;
      out_word[31:0] = rdata_q[63:32];
    end else begin
      out_word[31:0] = rdata_q[31:0];
    end
  end

  // IDLE pops combinationally, so hold the strobe off while reset is applied.
  assign r_en_CPU_to_FPGA_FIFO = pop && rst;
  assign w_en_FPGA_to_CPU_FIFO = push && rst;
  assign address_data_bus      = w_en_FPGA_to_CPU_FIFO ? out_word : {ADDRESS_DATA_WIDTH{1'bz}};

  assign bram_en    = mem_en;
  assign bram_we    = mem_we;
  assign bram_addr  = addr_q;
  assign bram_wdata = wdata_q;
  assign busy       = (state_q != S_IDLE);
  assign error      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_fpga_bram_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_fpga_bram_ctrl
//  Brief    : Directed bench for fpga_bram_ctrl with FIFO and BRAM models.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fpga_bram_ctrl;

  localparam int W     = 33;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          fpga_clk = 1'b0;
  logic          rst      = 1'b0;
  logic          empty;
  logic          full     = 1'b0;
  logic          r_en, w_en, bram_en, bram_we, busy, error;
  logic [AW-1:0] bram_addr;
  logic [63:0]   bram_wdata;
  logic [63:0]   bram_rdata = '0;
  wire  [W-1:0]  bus;

  // Command FIFO model: drives the popped word in the cycle after r_en.
  logic [W-1:0]  cmd_mem [0:63];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          fifo_drv_en = 1'b0;
  logic [W-1:0]  fifo_drv_data = '0;

  // Observations gathered at each rising edge.
  logic [W-1:0]  resp      [0:15];
  int            resp_cyc  [0:15];
  logic          resp_gap  [0:15];
  int            resp_cnt    = 0;
  int            cyc         = 0;
  int            we_cnt      = 0;
  int            en_cnt      = 0;
  int            overlap_cnt = 0;
  int            ren_viol    = 0;
  int            wen_viol    = 0;
  logic          prev_idle   = 1'b1;
  logic [AW-1:0] last_we_addr = '0;
  logic [63:0]   last_we_data = '0;
  logic [63:0]   bram_mem [0:DEPTH-1];

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  assign bus   = fifo_drv_en ? fifo_drv_data : {W{1'bz}};
  assign empty = (wr_ptr == rd_ptr);

  always #5 fpga_clk = ~fpga_clk;

  fpga_bram_ctrl #(
    .ADDRESS_DATA_WIDTH(W),
    .BRAM_DEPTH        (DEPTH)
  ) dut (
    .fpga_clk              (fpga_clk),
    .rst                   (rst),
    .empty_CPU_to_FPGA_FIFO(empty),
    .full_FPGA_to_CPU_FIFO (full),
    .r_en_CPU_to_FPGA_FIFO (r_en),
    .w_en_FPGA_to_CPU_FIFO (w_en),
    .address_data_bus      (bus),
    .bram_en               (bram_en),
    .bram_we               (bram_we),
    .bram_addr             (bram_addr),
    .bram_wdata            (bram_wdata),
    .bram_rdata            (bram_rdata),
    .busy                  (busy),
    .error                 (error)
  );

  // An undriven net reads as z in 4-state simulators and 0 in 2-state ones.
  function automatic logic bus_idle();
    return (bus === {W{1'bz}}) || (bus === {W{1'b0}});
  endfunction

  always @(posedge fpga_clk) begin
    fifo_drv_en <= r_en;
    if (r_en) begin
      fifo_drv_data <= cmd_mem[rd_ptr[5:0]];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  always @(posedge fpga_clk) begin
    if (bram_en) begin
      if (bram_we) bram_mem[bram_addr] <= bram_wdata;
      else         bram_rdata          <= bram_mem[bram_addr];
    end
  end

  always @(posedge fpga_clk) begin
    cyc       <= cyc + 1;
    prev_idle <= bus_idle();
    if (bram_en) en_cnt <= en_cnt + 1;
    if (bram_en && bram_we) begin
      we_cnt       <= we_cnt + 1;
      last_we_addr <= bram_addr;
      last_we_data <= bram_wdata;
    end
    if (r_en && w_en) overlap_cnt <= overlap_cnt + 1;
    if (r_en && empty) ren_viol <= ren_viol + 1;
    if (w_en && full)  wen_viol <= wen_viol + 1;
    if (w_en) begin
      resp[resp_cnt[3:0]]     <= bus;
      resp_cyc[resp_cnt[3:0]] <= cyc;
      resp_gap[resp_cnt[3:0]] <= prev_idle;
      resp_cnt                <= resp_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic [W-1:0] word);
    cmd_mem[wr_ptr[5:0]] = word;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_resp(input int n, input string tag);
    int k = 0;
    while (resp_cnt < n && k < 60) begin
      @(negedge fpga_clk);
      k++;
    end
    check({tag, "_timeout"}, 64'(resp_cnt >= n), 64'd1);
  endtask

  task automatic wait_we(input int n, input string tag);
    int k = 0;
    while (we_cnt < n && k < 60) begin
      @(negedge fpga_clk);
      k++;
    end
    check({tag, "_timeout"}, 64'(we_cnt >= n), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ren"},   64'(r_en),       64'd0);
    check({tag, "_wen"},   64'(w_en),       64'd0);
    check({tag, "_en"},    64'(bram_en),    64'd0);
    check({tag, "_we"},    64'(bram_we),    64'd0);
    check({tag, "_addr"},  64'(bram_addr),  64'd0);
    check({tag, "_wdata"}, bram_wdata,      64'd0);
    check({tag, "_busy"},  64'(busy),       64'd0);
    check({tag, "_error"}, 64'(error),      64'd0);
    check({tag, "_bus"},   64'(bus_idle()), 64'd1);
  endtask

  initial begin
    int t0, t1, en0, rp0, rc0, we0;

    // Reset state
    #12;
    check_reset_outputs("rst");
    @(negedge fpga_clk);
    rst = 1'b1;
    @(negedge fpga_clk);

    // WRITE 0x10 with FIFO never empty: 6-cycle latency, index 2
    push_cmd(33'h1_0000_0010);
    push_cmd(33'h0_1122_3344);
    push_cmd(33'h0_5566_7788);
    t0 = -1;
    t1 = -1;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (r_en && t0 < 0) t0 = k;
      if (bram_we) begin
        t1 = k;
        break;
      end
      @(negedge fpga_clk);
    end
    check("wr_latency", 64'(t1 - t0), 64'd6);
    check("wr_en",      64'(bram_en), 64'd1);
    check("wr_addr",    64'(bram_addr), 64'd2);
    check("wr_data",    bram_wdata, 64'h5566_7788_1122_3344);
    repeat (3) @(negedge fpga_clk);
    check("wr_pulses",  64'(we_cnt), 64'd1);
    check("wr_error",   64'(error), 64'd0);

    // READ 0x10 back
    push_cmd(33'h0_0000_0010);
    wait_resp(2, "rd");
    check("rd_lo",     64'(resp[0]), 64'h0_1122_3344);
    check("rd_hi",     64'(resp[1]), 64'h1_5566_7788);
    check("rd_gap",    64'(resp_gap[0]), 64'd1);
    check("rd_b2b",    64'(resp_cyc[1] - resp_cyc[0]), 64'd1);

    // READ with response FIFO full while in OUT_LO
    full = 1'b1;
    push_cmd(33'h0_0000_0010);
    repeat (8) @(negedge fpga_clk);
    #1;
    check("stall_busy", 64'(busy), 64'd1);
    for (int k = 0; k < 5; k++) begin
      check("stall_wen", 64'(w_en), 64'd0);
      check("stall_bus", 64'(bus_idle()), 64'd1);
      @(negedge fpga_clk);
      #1;
    end
    check("stall_nopush", 64'(resp_cnt), 64'd2);
    full = 1'b0;
    wait_resp(4, "stall");
    check("stall_lo",  64'(resp[2]), 64'h0_1122_3344);
    check("stall_hi",  64'(resp[3]), 64'h1_5566_7788);
    check("stall_b2b", 64'(resp_cyc[3] - resp_cyc[2]), 64'd1);

    // Unaligned WRITE then out-of-range READ
    en0 = en_cnt;
    rp0 = rd_ptr;
    push_cmd(33'h1_0000_0004);
    push_cmd(33'h0_AAAA_AAAA);
    push_cmd(33'h0_BBBB_BBBB);
    push_cmd(33'(DEPTH * 8));
    wait_resp(6, "bad");
    check("bad_noen",  64'(en_cnt - en0), 64'd0);
    check("bad_pops",  64'(rd_ptr - rp0), 64'd4);
    check("bad_lo",    64'(resp[4]), 64'h0_0000_0000);
    check("bad_hi",    64'(resp[5]), 64'h1_0000_0000);
    check("bad_error", 64'(error), 64'd1);

    // Command FIFO empty between data words
    we0 = we_cnt;
    push_cmd(33'h1_0000_0018);
    push_cmd(33'h0_0BAD_F00D);
    repeat (5) @(negedge fpga_clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("gap_ren",  64'(r_en), 64'd0);
      check("gap_busy", 64'(busy), 64'd1);
      @(negedge fpga_clk);
      #1;
    end
    push_cmd(33'h0_CAFE_F00D);
    wait_we(we0 + 1, "gap");
    check("gap_addr", 64'(last_we_addr), 64'd3);
    check("gap_data", last_we_data, 64'hCAFE_F00D_0BAD_F00D);
    push_cmd(33'h0_0000_0018);
    wait_resp(8, "gap_rd");
    check("gap_rd_lo", 64'(resp[6]), 64'h0_0BAD_F00D);
    check("gap_rd_hi", 64'(resp[7]), 64'h1_CAFE_F00D);
    check("sticky_error", 64'(error), 64'd1);

    // Reset during READ while stalled in OUT_LO
    full = 1'b1;
    push_cmd(33'h0_0000_0010);
    repeat (8) @(negedge fpga_clk);
    #1;
    check("mid_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge fpga_clk);
    rst  = 1'b1;
    full = 1'b0;
    rc0  = resp_cnt;
    we0  = we_cnt;
    push_cmd(33'h1_0000_0020);
    push_cmd(33'h0_0000_0001);
    push_cmd(33'h0_0000_0002);
    wait_we(we0 + 1, "post");
    check("post_addr",   64'(last_we_addr), 64'd4);
    check("post_data",   last_we_data, 64'h0000_0002_0000_0001);
    check("post_noresp", 64'(resp_cnt - rc0), 64'd0);

    // Strobe rules over the whole run
    repeat (2) @(negedge fpga_clk);
    check("overlap",  64'(overlap_cnt), 64'd0);
    check("ren_rule", 64'(ren_viol), 64'd0);
    check("wen_rule", 64'(wen_viol), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
